// File: rtl/or4_bist_ctrl.sv
// Self-test sequencer for a 4-input OR unit: walks all 16 input vectors,
// waits a settle time, checks the result and reports pass / error count / first failure.
module or4_bist_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_CNT_W     = 5
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   output logic                 o_a,
   output logic                 o_b,
   output logic                 o_c,
   output logic                 o_d,
   input  logic                 i_f,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_pass,
   output logic [ERR_CNT_W-1:0] o_err_cnt,
   output logic [3:0]           o_first_fail
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam logic [7:0]           SETTLE_LD = 8'(SETTLE_CYCLES);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

   state_t                 state_q, state_d;
   logic [3:0]             vec_q, vec_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [ERR_CNT_W-1:0]   err_q, err_d;
   logic [3:0]             ff_q, ff_d;
   logic                   seen_q, seen_d;
   logic                   pass_q, pass_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ff_d    = ff_q;
      seen_d  = seen_q;
      pass_d  = pass_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (i_start) begin
               state_d = ST_APPLY;
               vec_d   = 4'd0;
               err_d   = '0;
               ff_d    = 4'd0;
               seen_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         ST_APPLY: begin
            cnt_d   = SETTLE_LD;
            state_d = (SETTLE_LD == 8'd0) ? ST_CHECK : ST_SETTLE;
         end
         ST_SETTLE: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (i_f != (|vec_q)) begin
               if (err_q != ERR_MAX) begin
                  err_d = err_q + 1'b1;
               end
               // seen flag separates "failed at vector 0" from "never failed"
               if (!seen_q) begin
                  ff_d   = vec_q;
                  seen_d = 1'b1;
               end
            end
            if (vec_q == 4'hf) begin
               state_d = ST_DONE;
               pass_d  = (err_d == '0);
            end else begin
               vec_d   = vec_q + 4'd1;
               state_d = ST_APPLY;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_APPLY) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         vec_q   <= 4'd0;
         cnt_q   <= 8'd0;
         err_q   <= '0;
         ff_q    <= 4'd0;
         seen_q  <= 1'b0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         seen_q  <= seen_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_a          = vec_q[3];
   assign o_b          = vec_q[2];
   assign o_c          = vec_q[1];
   assign o_d          = vec_q[0];
   assign o_busy       = busy_q;
   assign o_done       = done_q;
   assign o_pass       = pass_q;
   assign o_err_cnt    = err_q;
   assign o_first_fail = ff_q;

endmodule

// File: tb/tb_or4_bist_ctrl.sv
// Bench for or4_bist_ctrl: three sequencer instances with different settle/width
// settings, each driving a behavioural OR4 model that can be forced stuck-at-0/1.
module tb_or4_bist_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       start_r [3];
   logic       rst_r   [3];
   int         mode_r  [3];
   logic       f_w     [3];
   logic [3:0] vec_w   [3];
   logic       busy_w  [3];
   logic       done_w  [3];
   logic       pass_w  [3];
   logic [4:0] err_w   [3];
   logic [3:0] ff_w    [3];

   int n_vec = 0;
   int n_err = 0;
   logic [3:0] sb_q[$];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int S = (g == 0) ? 2 : 0;
      localparam int W = (g == 2) ? 3 : 5;
      logic a, b, c, d, busy, done, pass;
      logic [W-1:0] err;
      logic [3:0] ff;

      or4_bist_ctrl #(.SETTLE_CYCLES(S), .ERR_CNT_W(W)) u_dut (
         .i_clk        (clk),
         .i_rst        (rst_r[g]),
         .i_start      (start_r[g]),
         .o_a          (a),
         .o_b          (b),
         .o_c          (c),
         .o_d          (d),
         .i_f          (f_w[g]),
         .o_busy       (busy),
         .o_done       (done),
         .o_pass       (pass),
         .o_err_cnt    (err),
         .o_first_fail (ff)
      );

      // mode 0: correct OR4, 1: stuck-at-0, 2: stuck-at-1
      assign f_w[g]    = (mode_r[g] == 0) ? (a | b | c | d) : (mode_r[g] == 2);
      assign vec_w[g]  = {a, b, c, d};
      assign busy_w[g] = busy;
      assign done_w[g] = done;
      assign pass_w[g] = pass;
      assign err_w[g]  = 5'(err);
      assign ff_w[g]   = ff;
   end

   // One full run on instance k; expected vectors go into the scoreboard queue
   // and the expected result comes from a small OR4/fault model.
   task automatic do_run(input int k, input int s, input int emax, input int poke);
      logic [3:0] vv, cur, prev, exp_v;
      int exp_err, exp_ff, held, busy_cnt;
      bit seen, first, poked, good, dutf;
      exp_err = 0; exp_ff = 0; seen = 0;
      sb_q.delete();
      for (int v = 0; v < 16; v++) begin
         vv   = v[3:0];
         good = |vv;
         dutf = (mode_r[k] == 0) ? good : (mode_r[k] == 2);
         if (dutf != good) begin
            if (exp_err < emax) exp_err++;
            if (!seen) begin exp_ff = v; seen = 1; end
         end
         sb_q.push_back(vv);
      end

      start_r[k] = 1'b1;
      @(negedge clk);
      start_r[k] = 1'b0;
      n_vec++;
      if (busy_w[k] !== 1'b1 || done_w[k] !== 1'b0) begin
         n_err++;
         $display("FAIL run%0d_start: busy=%b done=%b expected busy=1 done=0", k, busy_w[k], done_w[k]);
      end

      held = 0; busy_cnt = 0; first = 1; poked = 0; prev = 4'd0;
      for (int t = 0; t < 200 && done_w[k] !== 1'b1; t++) begin
         cur = vec_w[k];
         if (busy_w[k]) busy_cnt++;
         if (first || cur != prev) begin
            if (!first) begin
               n_vec++;
               if (held != s + 2) begin
                  n_err++;
                  $display("FAIL run%0d_hold: vec %h held %0d cycles expected %0d", k, prev, held, s + 2);
               end
            end
            n_vec++;
            if (sb_q.size() == 0) begin
               n_err++;
               $display("FAIL run%0d_seq: got vec %h expected none", k, cur);
            end else begin
               exp_v = sb_q.pop_front();
               if (cur !== exp_v) begin
                  n_err++;
                  $display("FAIL run%0d_seq: got vec %h expected %h", k, cur, exp_v);
               end
            end
            held  = 0;
            first = 0;
         end
         held++;
         prev = cur;
         if (poke >= 0 && !poked && cur == 4'(poke)) begin
            start_r[k] = 1'b1;
            poked = 1;
         end else begin
            start_r[k] = 1'b0;
         end
         @(negedge clk);
      end
      start_r[k] = 1'b0;

      n_vec++;
      if (done_w[k] !== 1'b1) begin
         n_err++;
         $display("FAIL run%0d_timeout: done=%b expected 1", k, done_w[k]);
      end
      n_vec++;
      if (busy_cnt != 16 * (s + 2)) begin
         n_err++;
         $display("FAIL run%0d_busy_len: got %0d expected %0d", k, busy_cnt, 16 * (s + 2));
      end
      n_vec++;
      if (held != s + 2 || sb_q.size() != 0) begin
         n_err++;
         $display("FAIL run%0d_tail: last hold %0d left %0d expected hold %0d left 0", k, held, sb_q.size(), s + 2);
      end
      n_vec++;
      if (busy_w[k] !== 1'b0 || vec_w[k] !== 4'hf) begin
         n_err++;
         $display("FAIL run%0d_done_state: busy=%b vec=%h expected busy=0 vec=f", k, busy_w[k], vec_w[k]);
      end
      n_vec++;
      if (err_w[k] !== 5'(exp_err)) begin
         n_err++;
         $display("FAIL run%0d_err_cnt: got %0d expected %0d", k, err_w[k], exp_err);
      end
      n_vec++;
      if (ff_w[k] !== 4'(exp_ff)) begin
         n_err++;
         $display("FAIL run%0d_first_fail: got %h expected %h", k, ff_w[k], exp_ff);
      end
      n_vec++;
      if (pass_w[k] !== (exp_err == 0)) begin
         n_err++;
         $display("FAIL run%0d_pass: got %b expected %b", k, pass_w[k], exp_err == 0);
      end
   endtask

   task automatic test_reset;
      for (int k = 0; k < 3; k++) begin
         rst_r[k] = 1'b1; start_r[k] = 1'b1; mode_r[k] = 0;
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 2) begin
            for (int k = 0; k < 3; k++) begin rst_r[k] = 1'b0; start_r[k] = 1'b0; end
         end
         for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (busy_w[k] !== 1'b0 || done_w[k] !== 1'b0 || pass_w[k] !== 1'b0 ||
                err_w[k] !== 5'd0 || ff_w[k] !== 4'd0 || vec_w[k] !== 4'd0) begin
               n_err++;
               $display("FAIL reset%0d: busy=%b done=%b pass=%b err=%0d ff=%h vec=%h expected all 0",
                        k, busy_w[k], done_w[k], pass_w[k], err_w[k], ff_w[k], vec_w[k]);
            end
         end
      end
   endtask

   task automatic test_good_run;
      mode_r[0] = 0;
      do_run(0, 2, 31, -1);
   endtask

   task automatic test_stuck_faults;
      mode_r[1] = 1;
      do_run(1, 0, 31, -1);
      mode_r[1] = 2;
      do_run(1, 0, 31, -1);
   endtask

   task automatic test_saturate_restart;
      mode_r[2] = 1;
      do_run(2, 0, 7, -1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if (done_w[2] !== 1'b1 || vec_w[2] !== 4'hf || err_w[2] !== 5'd7) begin
            n_err++;
            $display("FAIL hold_done: done=%b vec=%h err=%0d expected 1 f 7", done_w[2], vec_w[2], err_w[2]);
         end
      end
      mode_r[2] = 0;
      do_run(2, 0, 7, -1);
   endtask

   task automatic test_ignore_abort;
      mode_r[0] = 0;
      do_run(0, 2, 31, 5);
      mode_r[0] = 1;
      start_r[0] = 1'b1;
      @(negedge clk);
      start_r[0] = 1'b0;
      for (int t = 0; t < 100 && vec_w[0] !== 4'd9; t++) @(negedge clk);
      n_vec++;
      if (vec_w[0] !== 4'd9 || err_w[0] == 5'd0) begin
         n_err++;
         $display("FAIL abort_reach: vec=%h err=%0d expected vec 9 with errors", vec_w[0], err_w[0]);
      end
      rst_r[0] = 1'b1;
      @(negedge clk);
      rst_r[0] = 1'b0;
      n_vec++;
      if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || pass_w[0] !== 1'b0 ||
          err_w[0] !== 5'd0 || ff_w[0] !== 4'd0 || vec_w[0] !== 4'd0) begin
         n_err++;
         $display("FAIL abort_reset: busy=%b done=%b pass=%b err=%0d ff=%h vec=%h expected all 0",
                  busy_w[0], done_w[0], pass_w[0], err_w[0], ff_w[0], vec_w[0]);
      end
      mode_r[0] = 0;
      @(negedge clk);
      do_run(0, 2, 31, -1);
   endtask

   initial begin
      test_reset();
      test_good_run();
      test_stuck_faults();
      test_saturate_restart();
      test_ignore_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
